// File: rtl/t5_dmem_pkg.sv
// Shared T5 data-memory definitions: opcode and size encodings, bus FSM states.
package t5_dmem_pkg;

    localparam logic [4:0] OPC_LOAD  = 5'b00000;
    localparam logic [4:0] OPC_STORE = 5'b01000;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/t5_dmem_align.sv
// Combinational lane select, replicated store data and misalignment detect.
// Zero latency; no flow control.
module t5_dmem_align
    import t5_dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size_i,
    input  logic [1:0]      adr_i,
    input  logic            store_i,
    input  logic [XLEN-1:0] dat_i,
    output logic [3:0]      sel_o,
    output logic [XLEN-1:0] dto_o,
    output logic            mis_o
);

    always_comb begin
        sel_o = 4'h0;
        dto_o = '0;
        mis_o = 1'b0;
        case (size_i)
            SZ_B: begin
                sel_o = 4'b0001 << adr_i;
                dto_o = {(XLEN/8){dat_i[7:0]}};
            end
            SZ_H: begin
                mis_o = adr_i[0];
                sel_o = adr_i[1] ? 4'hC : 4'h3;
                dto_o = {(XLEN/16){dat_i[15:0]}};
            end
            SZ_W: begin
                mis_o = |adr_i;
                sel_o = 4'hF;
                dto_o = dat_i;
            end
            // Reserved size never reaches the bus.
            default: mis_o = 1'b1;
        endcase
        if (!store_i) begin
            dto_o = '0;
        end
    end

endmodule

// File: rtl/t5_dmem.sv
// Data Wishbone initiator: registers a decoded load/store, stb from the edge after accept.
// Holds the pipeline via dstall until ack or timeout; back-to-back issue on the ack cycle.
module t5_dmem
    import t5_dmem_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TMO  = 15
) (
    input  logic            sclk,
    input  logic            srst_n,
    input  logic            sena,
    input  logic [6:2]      xopc,
    input  logic [14:12]    xfn3,
    input  logic [XLEN-1:0] xalu,
    input  logic [XLEN-1:0] xrs2,
    input  logic            dwb_ack,
    output logic [XLEN-1:0] dwb_adr,
    output logic [XLEN-1:0] dwb_dto,
    output logic [3:0]      dwb_sel,
    output logic            dwb_stb,
    output logic            dwb_cyc,
    output logic            dwb_wre,
    output logic [3:0]      xsel,
    output logic            xstb,
    output logic            xwre,
    output logic            dstall,
    output logic            xmis,
    output logic            derr
);

    localparam int CW = $clog2(TMO + 1);

    dmem_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] adr_q, adr_d, dto_q, dto_d;
    logic [3:0]      sel_q, sel_d;
    logic            wre_q, wre_d, mis_q, mis_d;

    logic            is_st, req, slot, accept, busy, tmo_hit, al_mis;
    logic [3:0]      al_sel;
    logic [XLEN-1:0] al_dto;
    logic            unused_sgn;

    // Signedness is consumed by t5_back when it extends load data.
    assign unused_sgn = xfn3[14];

    t5_dmem_align #(.XLEN(XLEN)) u_align (
        .size_i  (xfn3[13:12]),
        .adr_i   (xalu[1:0]),
        .store_i (is_st),
        .dat_i   (xrs2),
        .sel_o   (al_sel),
        .dto_o   (al_dto),
        .mis_o   (al_mis)
    );

    assign is_st   = (xopc == OPC_STORE);
    assign req     = sena & ((xopc == OPC_LOAD) | is_st);
    assign busy    = (state_q == ST_BUSY);
    assign slot    = ~busy | dwb_ack;
    assign accept  = req & slot & ~al_mis;
    assign tmo_hit = busy & ~dwb_ack & (cnt_q == CW'(TMO));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dto_d   = dto_q;
        wre_d   = wre_q;
        mis_d   = req & slot & al_mis;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    state_d = ST_BUSY;
                end else if (dwb_ack || tmo_hit) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != CW'(TMO)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            cnt_d = '0;
            adr_d = {xalu[XLEN-1:2], 2'b00};
            sel_d = al_sel;
            dto_d = al_dto;
            wre_d = is_st;
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            sel_q   <= 4'h0;
            dto_q   <= '0;
            wre_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dto_q   <= dto_d;
            wre_q   <= wre_d;
            mis_q   <= mis_d;
        end
    end

    assign dwb_adr = adr_q;
    assign dwb_dto = dto_q;
    assign dwb_sel = sel_q;
    assign dwb_stb = busy;
    assign dwb_cyc = busy;
    assign dwb_wre = wre_q;
    assign xsel    = sel_q;
    assign xstb    = busy;
    assign xwre    = wre_q;
    assign dstall  = busy & ~dwb_ack & ~tmo_hit;
    assign xmis    = mis_q;
    assign derr    = tmo_hit;

endmodule

// File: tb/tb_t5_dmem.sv
// Bench for t5_dmem: directed scenarios plus random traffic against a transaction-level model.
module tb_t5_dmem;

    localparam int TMO = 3;
    localparam logic [4:0] LD = 5'b00000;
    localparam logic [4:0] ST = 5'b01000;
    localparam logic [4:0] OT = 5'b01100;

    logic        sclk = 1'b0;
    logic        srst_n, sena, dwb_ack;
    logic [6:2]  xopc;
    logic [14:12] xfn3;
    logic [31:0] xalu, xrs2;
    logic [31:0] dwb_adr, dwb_dto;
    logic [3:0]  dwb_sel, xsel;
    logic        dwb_stb, dwb_cyc, dwb_wre, xstb, xwre, dstall, xmis, derr;

    always #5 sclk = ~sclk;

    t5_dmem #(.XLEN(32), .TMO(TMO)) dut (
        .sclk(sclk), .srst_n(srst_n), .sena(sena), .xopc(xopc), .xfn3(xfn3),
        .xalu(xalu), .xrs2(xrs2), .dwb_ack(dwb_ack), .dwb_adr(dwb_adr),
        .dwb_dto(dwb_dto), .dwb_sel(dwb_sel), .dwb_stb(dwb_stb), .dwb_cyc(dwb_cyc),
        .dwb_wre(dwb_wre), .xsel(xsel), .xstb(xstb), .xwre(xwre), .dstall(dstall),
        .xmis(xmis), .derr(derr)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one outstanding transaction plus the number of cycles it has waited.
    bit          m_busy, m_mis, m_wre;
    int          m_wait;
    logic [31:0] m_adr, m_dto;
    logic [3:0]  m_sel;

    function automatic void ref_lanes(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                      input bit st, output bit mis, output logic [3:0] sel,
                                      output logic [31:0] dto);
        int nb;
        logic [3:0] mask;
        case (f3[1:0])
            2'd0:    nb = 1;
            2'd1:    nb = 2;
            2'd2:    nb = 4;
            default: nb = 0;
        endcase
        mis  = (nb == 0) || ((int'(a[1:0]) % nb) != 0);
        mask = 4'((1 << nb) - 1);
        sel  = mask << a[1:0];
        if (!st)          dto = 32'h0;
        else if (nb == 1) dto = a[1:0] == a[1:0] ? d[7:0] * 32'h01010101 : 32'h0;
        else if (nb == 2) dto = d[15:0] * 32'h00010001;
        else              dto = d;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_mis = 0; m_wre = 0; m_wait = 0;
        m_adr = 32'h0; m_dto = 32'h0; m_sel = 4'h0;
    endtask

    task automatic check_all();
        bit stall_e, err_e;
        stall_e = m_busy && !dwb_ack && (m_wait < TMO);
        err_e   = m_busy && !dwb_ack && (m_wait == TMO);
        chk("stb", dwb_stb, m_busy);
        chk("cyc", dwb_cyc, m_busy);
        chk("xstb", xstb, m_busy);
        chk("adr", dwb_adr, m_adr);
        chk("sel", dwb_sel, m_sel);
        chk("xsel", xsel, m_sel);
        chk("dto", dwb_dto, m_dto);
        chk("wre", dwb_wre, m_wre);
        chk("xwre", xwre, m_wre);
        chk("xmis", xmis, m_mis);
        chk("dstall", dstall, stall_e);
        chk("derr", derr, err_e);
    endtask

    task automatic model_step();
        bit valid, st, mis, slot;
        logic [3:0]  sel;
        logic [31:0] dto;
        st    = (xopc == ST);
        valid = sena && ((xopc == LD) || st);
        ref_lanes(xfn3, xalu, xrs2, st, mis, sel, dto);
        slot  = !m_busy || dwb_ack;
        m_mis = valid && slot && mis;
        if (valid && slot && !mis) begin
            m_busy = 1; m_wait = 0;
            m_adr = {xalu[31:2], 2'b00}; m_sel = sel; m_dto = dto; m_wre = st;
        end else if (m_busy && (dwb_ack || m_wait == TMO)) begin
            m_busy = 0;
        end else if (m_busy) begin
            m_wait++;
        end
    endtask

    // One bus cycle: drive, check mid-cycle, advance the model, return just after the edge.
    task automatic step(input bit en, input logic [4:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input bit ack);
        sena = en; xopc = op; xfn3 = f3; xalu = a; xrs2 = d; dwb_ack = ack;
        @(negedge sclk);
        check_all();
        model_step();
        @(posedge sclk);
        #1;
    endtask

    initial begin
        int ack_pct;
        logic [4:0] op;
        srst_n = 0; sena = 0; xopc = OT; xfn3 = 3'b0; xalu = 32'h0; xrs2 = 32'h0; dwb_ack = 0;
        model_reset();
        @(negedge sclk);
        check_all();
        @(posedge sclk);
        #1 srst_n = 1;

        // Store word, two wait cycles, then ack.
        step(1, ST, 3'b010, 32'h100, 32'hDEADBEEF, 0);
        chk("sw_adr", dwb_adr, 32'h100);
        chk("sw_sel", dwb_sel, 4'hF);
        chk("sw_dto", dwb_dto, 32'hDEADBEEF);
        chk("sw_wre", dwb_wre, 1'b1);
        step(0, OT, 3'b0, 32'h0, 32'h0, 0);
        step(0, OT, 3'b0, 32'h0, 32'h0, 0);
        step(0, OT, 3'b0, 32'h0, 32'h0, 1);
        chk("sw_done", dwb_stb, 1'b0);

        // Load byte at lane 3.
        step(1, LD, 3'b000, 32'h103, 32'h0, 0);
        chk("lb_sel", dwb_sel, 4'h8);
        chk("lb_wre", dwb_wre, 1'b0);
        chk("lb_dto", dwb_dto, 32'h0);
        step(0, OT, 3'b0, 32'h0, 32'h0, 1);

        // Store half then back-to-back load word on the ack cycle.
        step(1, ST, 3'b001, 32'h202, 32'h1234ABCD, 0);
        chk("sh_sel", dwb_sel, 4'hC);
        chk("sh_dto", dwb_dto, 32'hABCDABCD);
        step(1, LD, 3'b010, 32'h204, 32'h0, 1);
        chk("b2b_stb", dwb_stb, 1'b1);
        chk("b2b_adr", dwb_adr, 32'h204);
        chk("b2b_sel", dwb_sel, 4'hF);
        step(0, OT, 3'b0, 32'h0, 32'h0, 1);

        // Misaligned word and half.
        step(1, LD, 3'b010, 32'h101, 32'h0, 0);
        chk("mis_w", xmis, 1'b1);
        chk("mis_w_stb", dwb_stb, 1'b0);
        step(1, LD, 3'b001, 32'h0FF, 32'h0, 0);
        chk("mis_h", xmis, 1'b1);
        step(0, OT, 3'b0, 32'h0, 32'h0, 0);
        chk("mis_end", xmis, 1'b0);

        // Timeout, then a late ack while idle.
        step(1, ST, 3'b010, 32'h400, 32'h55AA55AA, 0);
        for (int i = 0; i <= TMO; i++) step(0, OT, 3'b0, 32'h0, 32'h0, 0);
        chk("tmo_stb", dwb_stb, 1'b0);
        step(0, OT, 3'b0, 32'h0, 32'h0, 1);
        chk("late_ack", dwb_stb, 1'b0);

        // Ack in the timeout cycle wins.
        step(1, LD, 3'b010, 32'h500, 32'h0, 0);
        for (int i = 0; i < TMO; i++) step(0, OT, 3'b0, 32'h0, 32'h0, 0);
        step(0, OT, 3'b0, 32'h0, 32'h0, 1);

        // Reset while busy.
        step(1, ST, 3'b010, 32'h300, 32'h11223344, 0);
        sena = 0; dwb_ack = 0;
        #1 srst_n = 0;
        #1;
        chk("rst_stb", dwb_stb, 1'b0);
        chk("rst_cyc", dwb_cyc, 1'b0);
        chk("rst_adr", dwb_adr, 32'h0);
        chk("rst_sel", dwb_sel, 4'h0);
        chk("rst_dto", dwb_dto, 32'h0);
        chk("rst_derr", derr, 1'b0);
        model_reset();
        @(posedge sclk);
        #1 srst_n = 1;
        step(1, ST, 3'b000, 32'h301, 32'h000000A5, 0);
        chk("post_rst_stb", dwb_stb, 1'b1);
        chk("post_rst_dto", dwb_dto, 32'hA5A5A5A5);
        step(0, OT, 3'b0, 32'h0, 32'h0, 1);

        // Random traffic with varying ack density.
        for (int c = 0; c < 3000; c++) begin
            case ((c / 500) % 3)
                0:       ack_pct = 10;
                1:       ack_pct = 45;
                default: ack_pct = 90;
            endcase
            case ($urandom % 5)
                0, 1:    op = LD;
                2, 3:    op = ST;
                default: op = OT;
            endcase
            step(($urandom % 5) != 0, op, 3'($urandom), $urandom, $urandom,
                 ($urandom % 100) < ack_pct);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
